// File: rtl/bist_fail_log.sv
// ---------------------------------------------------------------------------
// bist_fail_log
//
// Purpose:
//   Collects read-compare mismatches reported by a memory BIST controller.
//   Each strobed compare is registered in a one-stage compare pipeline. A
//   mismatch ("hit") is pushed into a small FIFO log on the following edge,
//   so the hit-to-log latency is 2 edges. A consumer drains the log through
//   a valid/ready handshake. Running statistics are kept alongside the log:
//   a saturating mismatch counter, a sticky overflow flag for hits dropped
//   on a full log, and a sticky overall fail flag.
//
// Optional feature:
//   Define BIST_FAIL_LOG_BITMAP_EN to build fail_bitmap as the OR of every
//   registered syndrome, including hits dropped on overflow. Without the
//   macro fail_bitmap is tied to zero and no bitmap register exists.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             pulse: clear log/statistics and enter COLLECT
//   bist_done         level: leave COLLECT for DONE
//   cmp_valid         compare strobe for this cycle
//   cmp_addr/pass     address and March element index of the compared word
//   cmp_expected      expected data word
//   cmp_actual        data word read back from the SRAM
//   log_ready         consumer accepts the head entry
//   log_valid         head entry present
//   log_addr/pass     head entry address and pass index (0 when empty)
//   log_syndrome      head entry expected XOR actual (0 when empty)
//   log_count         number of entries held, 0..DEPTH
//   fail_count        total mismatches seen, saturating at 16'hFFFF
//   overflow          sticky: a mismatch was dropped on a full log
//   bist_fail         sticky: at least one mismatch was seen
//   busy              high while in COLLECT
//   fail_bitmap       OR of all syndromes (zero unless the macro is set)
// ---------------------------------------------------------------------------
module bist_fail_log #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              bist_done,
  input  logic              cmp_valid,
  input  logic [ADDR_W-1:0] cmp_addr,
  input  logic [2:0]        cmp_pass,
  input  logic [DATA_W-1:0] cmp_expected,
  input  logic [DATA_W-1:0] cmp_actual,
  input  logic              log_ready,
  output logic              log_valid,
  output logic [ADDR_W-1:0] log_addr,
  output logic [2:0]        log_pass,
  output logic [DATA_W-1:0] log_syndrome,
  output logic [4:0]        log_count,
  output logic [15:0]       fail_count,
  output logic              overflow,
  output logic              bist_fail,
  output logic              busy,
  output logic [DATA_W-1:0] fail_bitmap
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Compare stage
  logic              hit_q, hit_d;
  logic [DATA_W-1:0] hit_syn_q, hit_syn_d;
  logic [ADDR_W-1:0] hit_addr_q, hit_addr_d;
  logic [2:0]        hit_pass_q, hit_pass_d;

  // Log control
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [4:0]        count_q, count_d;
  logic [15:0]       fail_count_q, fail_count_d;
  logic              overflow_q, overflow_d;
  logic              bist_fail_q, bist_fail_d;

  // Log storage (not reset; only pointers and count carry state)
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [2:0]        mem_pass [DEPTH];
  logic [DATA_W-1:0] mem_syn  [DEPTH];

  logic full;
  logic pop;
  logic push;
  logic drop;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  // start has priority everywhere, so a start together with bist_done
  // restarts collection instead of finishing it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = COLLECT;
      COLLECT: if (start) state_d = COLLECT;
               else if (bist_done) state_d = DONE;
      DONE:    if (start) state_d = COLLECT;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (state_q == COLLECT);
  end

  // ---------------- Compare stage ----------------
  // Only sampled while collecting; start flushes whatever would be captured.
  always_comb begin
    hit_d      = 1'b0;
    hit_syn_d  = '0;
    hit_addr_d = '0;
    hit_pass_d = '0;
    if (!start && (state_q == COLLECT)) begin
      hit_d      = cmp_valid && (cmp_expected != cmp_actual);
      hit_syn_d  = cmp_expected ^ cmp_actual;
      hit_addr_d = cmp_addr;
      hit_pass_d = cmp_pass;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q      <= 1'b0;
      hit_syn_q  <= '0;
      hit_addr_q <= '0;
      hit_pass_q <= '0;
    end else begin
      hit_q      <= hit_d;
      hit_syn_q  <= hit_syn_d;
      hit_addr_q <= hit_addr_d;
      hit_pass_q <= hit_pass_d;
    end
  end

  // ---------------- Log control ----------------
  // A full log still accepts a push when the head is popped in the same
  // cycle. start overrides both push and pop.
  assign log_valid = (count_q != 5'd0);
  assign full      = (count_q == 5'(DEPTH));
  assign pop       = log_valid && log_ready && !start;
  assign push      = hit_q && (!full || pop) && !start;
  assign drop      = hit_q && full && !pop && !start;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    fail_count_d = fail_count_q;
    overflow_d   = overflow_q;
    bist_fail_d  = bist_fail_q;
    if (start) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      fail_count_d = '0;
      overflow_d   = 1'b0;
      bist_fail_d  = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 5'd1;
        2'b01:   count_d = count_q - 5'd1;
        default: count_d = count_q;
      endcase
      if (hit_q) begin
        bist_fail_d = 1'b1;
        if (fail_count_q != 16'hFFFF) fail_count_d = fail_count_q + 16'd1;
      end
      if (drop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      fail_count_q <= '0;
      overflow_q   <= 1'b0;
      bist_fail_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      fail_count_q <= fail_count_d;
      overflow_q   <= overflow_d;
      bist_fail_q  <= bist_fail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr_q] <= hit_addr_q;
      mem_pass[wr_ptr_q] <= hit_pass_q;
      mem_syn[wr_ptr_q]  <= hit_syn_q;
    end
  end

  // Head payload is forced to zero when the log is empty so stale storage
  // never leaks onto the outputs.
  always_comb begin
    log_addr     = '0;
    log_pass     = '0;
    log_syndrome = '0;
    if (log_valid) begin
      log_addr     = mem_addr[rd_ptr_q];
      log_pass     = mem_pass[rd_ptr_q];
      log_syndrome = mem_syn[rd_ptr_q];
    end
  end

  assign log_count  = count_q;
  assign fail_count = fail_count_q;
  assign overflow   = overflow_q;
  assign bist_fail  = bist_fail_q;

  // ---------------- Optional fail bitmap ----------------
`ifdef BIST_FAIL_LOG_BITMAP_EN
  logic [DATA_W-1:0] bitmap_q, bitmap_d;

  // Dropped hits still contribute, so the bitmap covers every failing bit.
  always_comb begin
    bitmap_d = bitmap_q;
    if (start)      bitmap_d = '0;
    else if (hit_q) bitmap_d = bitmap_q | hit_syn_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bitmap_q <= '0;
    else        bitmap_q <= bitmap_d;
  end

  assign fail_bitmap = bitmap_q;
`else
  assign fail_bitmap = '0;
`endif

endmodule

// File: tb/tb_bist_fail_log.sv
// ---------------------------------------------------------------------------
// tb_bist_fail_log
//
// Directed bench for bist_fail_log with DEPTH=8. A table of per-cycle
// vectors walks through the basic hit/log/pop flow and the state machine,
// followed by hand-written sequences for overflow, full-log push+pop,
// start/clear interactions, asynchronous reset and the fail bitmap.
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge.
// ---------------------------------------------------------------------------
module tb_bist_fail_log;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        bist_done;
  logic        cmp_valid;
  logic [13:0] cmp_addr;
  logic [2:0]  cmp_pass;
  logic [31:0] cmp_expected;
  logic [31:0] cmp_actual;
  logic        log_ready;
  logic        log_valid;
  logic [13:0] log_addr;
  logic [2:0]  log_pass;
  logic [31:0] log_syndrome;
  logic [4:0]  log_count;
  logic [15:0] fail_count;
  logic        overflow;
  logic        bist_fail;
  logic        busy;
  logic [31:0] fail_bitmap;

  int errors = 0;
  int checks = 0;

  bist_fail_log #(.DEPTH(8), .ADDR_W(14), .DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .bist_done    (bist_done),
    .cmp_valid    (cmp_valid),
    .cmp_addr     (cmp_addr),
    .cmp_pass     (cmp_pass),
    .cmp_expected (cmp_expected),
    .cmp_actual   (cmp_actual),
    .log_ready    (log_ready),
    .log_valid    (log_valid),
    .log_addr     (log_addr),
    .log_pass     (log_pass),
    .log_syndrome (log_syndrome),
    .log_count    (log_count),
    .fail_count   (fail_count),
    .overflow     (overflow),
    .bist_fail    (bist_fail),
    .busy         (busy),
    .fail_bitmap  (fail_bitmap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        start;
    logic        done;
    logic        valid;
    logic        ready;
    logic [13:0] addr;
    logic [2:0]  pass;
    logic [31:0] exp;
    logic [31:0] act;
    logic        e_valid;
    logic [4:0]  e_count;
    logic [13:0] e_addr;
    logic [2:0]  e_pass;
    logic [31:0] e_syn;
    logic [15:0] e_fc;
    logic        e_bf;
    logic        e_busy;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[14];

  // Compare one value and report a mismatch
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, return just after the rising edge
  task automatic applyStimulus(input logic s, input logic d, input logic v,
                               input logic r, input logic [13:0] a,
                               input logic [2:0] p, input logic [31:0] e,
                               input logic [31:0] x);
    @(negedge clk);
    start        = s;
    bist_done    = d;
    cmp_valid    = v;
    log_ready    = r;
    cmp_addr     = a;
    cmp_pass     = p;
    cmp_expected = e;
    cmp_actual   = x;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 14'h0, 3'd0, 32'h0, 32'h0);
  endtask

  task automatic doStart();
    applyStimulus(1, 0, 0, 0, 14'h0, 3'd0, 32'h0, 32'h0);
  endtask

  task automatic hitCycle(input logic [13:0] a, input logic [31:0] syn, input logic r);
    applyStimulus(0, 0, 1, r, a, 3'd1, 32'h0, syn);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, 32'(log_valid), 32'h0);
    checkOutput({tag, "_count"}, 32'(log_count), 32'h0);
    checkOutput({tag, "_addr"}, 32'(log_addr), 32'h0);
    checkOutput({tag, "_pass"}, 32'(log_pass), 32'h0);
    checkOutput({tag, "_syn"}, log_syndrome, 32'h0);
    checkOutput({tag, "_fc"}, 32'(fail_count), 32'h0);
    checkOutput({tag, "_ovf"}, 32'(overflow), 32'h0);
    checkOutput({tag, "_bf"}, 32'(bist_fail), 32'h0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
    checkOutput({tag, "_bitmap"}, fail_bitmap, 32'h0);
  endtask

  initial begin
    logic [31:0] expBitmap;

    // start done valid ready addr pass exp act | valid count addr pass syn fc bf busy ovf
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 14'h0000, 3'd0, 32'h0, 32'h0,
                 1'b0, 5'd0, 14'h0000, 3'd0, 32'h0, 16'd0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 14'h0123, 3'd2, 32'hAAAAAAAA, 32'hAAAAAAAB,
                 1'b0, 5'd0, 14'h0000, 3'd0, 32'h0, 16'd0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 3'd0, 32'h0, 32'h0,
                 1'b1, 5'd1, 14'h0123, 3'd2, 32'h1, 16'd1, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 14'h0200, 3'd3, 32'h0, 32'h10,
                 1'b1, 5'd1, 14'h0123, 3'd2, 32'h1, 16'd1, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 14'h0300, 3'd1, 32'hFFFFFFFF, 32'h7FFFFFFF,
                 1'b1, 5'd1, 14'h0200, 3'd3, 32'h10, 16'd2, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 3'd0, 32'h0, 32'h0,
                 1'b1, 5'd2, 14'h0200, 3'd3, 32'h10, 16'd3, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 14'h0000, 3'd0, 32'h0, 32'h0,
                 1'b1, 5'd1, 14'h0300, 3'd1, 32'h80000000, 16'd3, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 14'h0777, 3'd5, 32'h55555555, 32'h55555555,
                 1'b0, 5'd0, 14'h0000, 3'd0, 32'h0, 16'd3, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 14'h0400, 3'd4, 32'h0, 32'h00000F00,
                 1'b0, 5'd0, 14'h0000, 3'd0, 32'h0, 16'd3, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 14'h0500, 3'd6, 32'h0, 32'hFFFFFFFF,
                 1'b1, 5'd1, 14'h0400, 3'd4, 32'hF00, 16'd4, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 3'd0, 32'h0, 32'h0,
                 1'b1, 5'd1, 14'h0400, 3'd4, 32'hF00, 16'd4, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 14'h0000, 3'd0, 32'h0, 32'h0,
                 1'b0, 5'd0, 14'h0000, 3'd0, 32'h0, 16'd4, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 14'h0600, 3'd2, 32'h0, 32'h1,
                 1'b0, 5'd0, 14'h0000, 3'd0, 32'h0, 16'd0, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 3'd0, 32'h0, 32'h0,
                 1'b0, 5'd0, 14'h0000, 3'd0, 32'h0, 16'd0, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
    start = 1'b0; bist_done = 1'b0; cmp_valid = 1'b0; log_ready = 1'b0;
    cmp_addr = '0; cmp_pass = '0; cmp_expected = '0; cmp_actual = '0;
    #1;
    checkAllZero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] table vectors");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].start, vecs[i].done, vecs[i].valid, vecs[i].ready,
                    vecs[i].addr, vecs[i].pass, vecs[i].exp, vecs[i].act);
      checkOutput($sformatf("v%0d_valid", i), 32'(log_valid), 32'(vecs[i].e_valid));
      checkOutput($sformatf("v%0d_count", i), 32'(log_count), 32'(vecs[i].e_count));
      checkOutput($sformatf("v%0d_addr", i), 32'(log_addr), 32'(vecs[i].e_addr));
      checkOutput($sformatf("v%0d_pass", i), 32'(log_pass), 32'(vecs[i].e_pass));
      checkOutput($sformatf("v%0d_syn", i), log_syndrome, vecs[i].e_syn);
      checkOutput($sformatf("v%0d_fc", i), 32'(fail_count), 32'(vecs[i].e_fc));
      checkOutput($sformatf("v%0d_bf", i), 32'(bist_fail), 32'(vecs[i].e_bf));
      checkOutput($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      checkOutput($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
    end

    $display("[TB] clean run of 100 matching compares");
    doStart();
    for (int i = 0; i < 100; i++)
      applyStimulus(0, 0, 1, 0, 14'(i), 3'd1, 32'h55555555, 32'h55555555);
    applyStimulus(0, 1, 0, 0, 14'h0, 3'd0, 32'h0, 32'h0);
    idleCycles(2);
    checkOutput("clean_valid", 32'(log_valid), 32'h0);
    checkOutput("clean_fc", 32'(fail_count), 32'h0);
    checkOutput("clean_bf", 32'(bist_fail), 32'h0);
    checkOutput("clean_busy", 32'(busy), 32'h0);

    $display("[TB] overflow with 10 hits");
    doStart();
    for (int i = 0; i < 10; i++) hitCycle(14'(16 + i), 32'h1, 1'b0);
    idleCycles(2);
    checkOutput("ovf_count", 32'(log_count), 32'd8);
    checkOutput("ovf_flag", 32'(overflow), 32'h1);
    checkOutput("ovf_fc", 32'(fail_count), 32'd10);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("ovf_drain%0d", i), 32'(log_addr), 32'(16 + i));
      applyStimulus(0, 0, 0, 1, 14'h0, 3'd0, 32'h0, 32'h0);
    end
    checkOutput("ovf_drained", 32'(log_count), 32'd0);

    $display("[TB] full log with push and pop together");
    doStart();
    for (int i = 0; i < 9; i++) hitCycle(14'(32 + i), 32'h2, 1'b0);
    checkOutput("full_before", 32'(log_count), 32'd8);
    applyStimulus(0, 0, 0, 1, 14'h0, 3'd0, 32'h0, 32'h0);
    checkOutput("full_count", 32'(log_count), 32'd8);
    checkOutput("full_ovf", 32'(overflow), 32'h0);
    checkOutput("full_fc", 32'(fail_count), 32'd9);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("full_drain%0d", i), 32'(log_addr), 32'(33 + i));
      applyStimulus(0, 0, 0, 1, 14'h0, 3'd0, 32'h0, 32'h0);
    end
    checkOutput("full_drained", 32'(log_valid), 32'h0);

    $display("[TB] start against registered hit and against pop");
    doStart();
    hitCycle(14'h0050, 32'h4, 1'b0);
    doStart();
    checkOutput("clr_hit_fc", 32'(fail_count), 32'd0);
    idleCycles(1);
    checkOutput("clr_hit_count", 32'(log_count), 32'd0);
    checkOutput("clr_hit_bf", 32'(bist_fail), 32'd0);
    hitCycle(14'h0051, 32'h4, 1'b0);
    idleCycles(2);
    checkOutput("clr_pop_pre", 32'(log_count), 32'd1);
    applyStimulus(1, 0, 0, 1, 14'h0, 3'd0, 32'h0, 32'h0);
    checkOutput("clr_pop_count", 32'(log_count), 32'd0);
    checkOutput("clr_pop_valid", 32'(log_valid), 32'd0);

    $display("[TB] asynchronous reset mid-collection");
    doStart();
    for (int i = 0; i < 5; i++) hitCycle(14'(64 + i), 32'h8, 1'b0);
    idleCycles(2);
    checkOutput("arst_pre", 32'(log_count), 32'd5);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("arst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idleCycles(2);
    checkOutput("arst_idle_busy", 32'(busy), 32'h0);
    checkOutput("arst_idle_count", 32'(log_count), 32'h0);
    doStart();
    hitCycle(14'h0099, 32'h8, 1'b0);
    idleCycles(2);
    checkOutput("arst_after", 32'(log_count), 32'd1);
    checkOutput("arst_after_addr", 32'(log_addr), 32'h0099);

    $display("[TB] fail bitmap");
    doStart();
    hitCycle(14'h0001, 32'h00000001, 1'b1);
    hitCycle(14'h0002, 32'h80000000, 1'b1);
    hitCycle(14'h0003, 32'h00000001, 1'b1);
    idleCycles(2);
`ifdef BIST_FAIL_LOG_BITMAP_EN
    expBitmap = 32'h80000001;
`else
    expBitmap = 32'h0;
`endif
    checkOutput("bitmap", fail_bitmap, expBitmap);
    doStart();
    checkOutput("bitmap_clr", fail_bitmap, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bist_fail_log.md
BIST_FAIL_LOG -- requirements
Module: bist_fail_log

Interface
REQ-001 Parameters:
- DEPTH, 8, failure-log entries (power of two, 2..16).
- ADDR_W, 14, width of the memory address under test.
- DATA_W, 32, memory word width.

REQ-002 Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse: clear log and begin collecting.
- bist_done  in  1  level from the BIST controller; ends collection.
- cmp_valid  in  1  read-compare strobe for this cycle.
- cmp_addr  in  ADDR_W  address of the word read.
- cmp_pass  in  3  March element / background index (1..6).
- cmp_expected  in  DATA_W  expected word (p0/p1 background).
- cmp_actual  in  DATA_W  word returned by SRAM Q.
- log_ready  in  1  consumer accepts the head entry.
- log_valid  out  1  head entry available.
- log_addr  out  ADDR_W  head entry address.
- log_pass  out  3  head entry pass index.
- log_syndrome  out  DATA_W  head entry expected XOR actual.
- log_count  out  5  entries held, 0..DEPTH.
- fail_count  out  16  total mismatches seen, saturating.
- overflow  out  1  sticky: a mismatch was dropped because the log was full.
- bist_fail  out  1  sticky: at least one mismatch seen.
- busy  out  1  high while in COLLECT.
- fail_bitmap  out  DATA_W  OR of all syndromes (see Configuration).

Function
REQ-003 FSM states are IDLE, COLLECT and DONE.
- IDLE goes to COLLECT on start.
- COLLECT goes to DONE on bist_done=1.
- DONE goes to COLLECT on start.
- start while in COLLECT restarts COLLECT.
REQ-004 start, in any state, clears the log, fail_count, overflow, bist_fail, fail_bitmap and the compare stage at that edge.
REQ-005 The compare stage samples on every edge in COLLECT:
- hit = cmp_valid AND (cmp_expected != cmp_actual);
- syndrome = cmp_expected XOR cmp_actual;
- cmp_addr and cmp_pass are registered alongside.
REQ-006 A hit registered at edge k is written to the log at edge k+1; log_valid is high after edge k+1. Fixed latency is 2 edges, with no bubbles at one hit per cycle.
REQ-007 On each registered hit, fail_count increments, saturating at 16'hFFFF, and bist_fail is set. Both update at edge k+1.
REQ-008 A registered hit with log_count=DEPTH and no pop in the same cycle is dropped and sets overflow. fail_count still increments.
REQ-009 Push and pop in the same cycle are both accepted, including when the log is full; log_count is unchanged.
REQ-010 Pop occurs when log_valid AND log_ready. The next entry, if any, is presented after the same edge.
REQ-011 log_* outputs hold stable while log_valid=1 and log_ready=0.
REQ-012 log_addr, log_pass and log_syndrome are 0 when log_valid=0.
REQ-013 The log is first-in first-out: entries are read in hit order, with wrap-around read and write pointers modulo DEPTH.
REQ-014 In IDLE and DONE, cmp_valid is ignored and no new hits are registered. A hit already registered when bist_done arrives is still written. Readout continues in every state.
REQ-015 start in the same cycle as a registered hit: the clear wins and the hit is discarded.
REQ-016 start in the same cycle as a pop: the clear wins, log_count=0 and log_valid=0 after that edge.
REQ-017 busy = (state == COLLECT).

Reset
REQ-018 rst_n=0 forces, asynchronously: state IDLE, pointers 0, log_count=0, log_valid=0, log_addr/log_pass/log_syndrome=0, fail_count=0, overflow=0, bist_fail=0, busy=0, fail_bitmap=0, compare stage cleared.
REQ-019 Reset asserted mid-collection discards all logged entries. After release the block stays in IDLE until start.
REQ-020 Log storage contents need no reset; only the pointers and count are reset.

Configuration
REQ-021 With BIST_FAIL_LOG_BITMAP_EN defined:
- fail_bitmap ORs in each registered hit's syndrome at edge k+1, including dropped hits;
- fail_bitmap is cleared by start and by reset.
REQ-022 Without BIST_FAIL_LOG_BITMAP_EN, fail_bitmap is constant 0 and no bitmap register is synthesized.

Verification
REQ-023 Scenario: reset, then start, then 100 cmp_valid with expected=actual=32'h55555555, then bist_done.
- Required: log_valid=0, fail_count=0, bist_fail=0, state DONE, busy=0.
REQ-024 Scenario: single hit, addr 14'h0123, pass 2, expected 32'hAAAAAAAA, actual 32'hAAAAAAAB, with log_ready=0.
- Required: log_valid high exactly 2 edges after the strobe.
- Required: log_syndrome=32'h00000001, log_addr=14'h0123, log_pass=2, fail_count=1.
- Then log_ready=1 for one cycle. Required: log_count=0.
REQ-025 Scenario: 10 consecutive hits with log_ready=0, DEPTH=8.
- Required: log_count=8, overflow=1, fail_count=10.
- Draining yields the first 8 addresses in order.
REQ-026 Scenario: log full with log_ready=1 and a hit arriving the same cycle.
- Required: log_count stays 8, overflow stays 0, entry order preserved.
REQ-027 Scenario: rst_n pulsed low mid-collection with 5 entries logged.
- Required: all outputs 0 immediately, without waiting for a clock edge.
- After release, start followed by one hit gives log_count=1.
REQ-028 Scenario, BIST_FAIL_LOG_BITMAP_EN defined: hits with syndromes 32'h1, then 32'h80000000, then 32'h1.
- Required: fail_bitmap=32'h80000001.
- Same stimulus without the macro: fail_bitmap=0.
